// File: rtl/pwm_param_calc.sv
// Period / duty-cycle (permille) calculator fed by the high/low pulse-width counter.
// Optional macro PWM_CALC_ROUND_EN selects round-half-up instead of truncating division.
module pwm_param_calc #(
    parameter int CNT_W  = 16,
    parameter int SCALE  = 1000,
    parameter int DUTY_W = $clog2(SCALE + 1),
    parameter int NUM_W  = CNT_W + 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  high_cnt,
    input  logic [CNT_W-1:0]  low_cnt,
    output logic [CNT_W:0]    period,
    output logic [DUTY_W-1:0] duty,
    output logic              zero_period,
    output logic              result_valid,
    output logic              busy
);

`ifdef PWM_CALC_ROUND_EN
    localparam int DIV_W = NUM_W + 1;
`else
    localparam int DIV_W = NUM_W;
`endif
    localparam int PER_W  = CNT_W + 1;
    localparam int REM_W  = CNT_W + 2;
    localparam int ITER_W = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  snap_high;
    logic [CNT_W-1:0]  snap_low;
    logic [PER_W-1:0]  per_q;
    logic [DIV_W-1:0]  quo;
    logic [REM_W-1:0]  rem;
    logic [ITER_W-1:0] iter;

    logic              changed;
    logic [PER_W-1:0]  per_sum;
    logic [DIV_W-1:0]  num_load;
    logic [REM_W-1:0]  rem_shift;
    logic              sub_ok;
    logic [REM_W-1:0]  rem_next;
    logic [DIV_W-1:0]  quo_next;

    assign busy = (state != IDLE);

    always_comb begin
        changed   = (high_cnt != snap_high) || (low_cnt != snap_low);
        per_sum   = PER_W'(snap_high) + PER_W'(snap_low);
`ifdef PWM_CALC_ROUND_EN
        num_load  = DIV_W'(snap_high) * DIV_W'(SCALE) + DIV_W'(per_sum >> 1);
`else
        num_load  = DIV_W'(snap_high) * DIV_W'(SCALE);
`endif
        // Numerator bits shift out of quo's MSB while quotient bits shift in at its LSB.
        rem_shift = {rem[REM_W-2:0], quo[DIV_W-1]};
        sub_ok    = (rem_shift >= REM_W'(per_q));
        rem_next  = sub_ok ? (rem_shift - REM_W'(per_q)) : rem_shift;
        quo_next  = {quo[DIV_W-2:0], sub_ok};
    end

    // Busy-time input changes need no separate pending flag: IDLE always
    // re-compares the live inputs against the snapshot before restarting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            snap_high    <= '0;
            snap_low     <= '0;
            per_q        <= '0;
            quo          <= '0;
            rem          <= '0;
            iter         <= '0;
            period       <= '0;
            duty         <= '0;
            zero_period  <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_valid <= 1'b0;
                    if (changed) begin
                        snap_high <= high_cnt;
                        snap_low  <= low_cnt;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    per_q <= per_sum;
                    quo   <= num_load;
                    rem   <= '0;
                    iter  <= '0;
                    state <= DIV;
                end
                DIV: begin
                    rem  <= rem_next;
                    quo  <= quo_next;
                    iter <= iter + ITER_W'(1);
                    // Results are registered on the last iteration so they are visible during DONE.
                    if (iter == ITER_W'(DIV_W - 1)) begin
                        period       <= per_q;
                        zero_period  <= (per_q == '0);
                        duty         <= (per_q == '0) ? '0 : quo_next[DUTY_W-1:0];
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_param_calc.sv
// Self-checking bench for pwm_param_calc: per-cycle behavioural model plus directed literal checks.
// Honours PWM_CALC_ROUND_EN the same way as the design.
module tb_pwm_param_calc;
    localparam int CNT_W  = 16;
    localparam int DUTY_W = 10;
`ifdef PWM_CALC_ROUND_EN
    localparam int LAT = 29;
    localparam int DUTY_2_1 = 667;
`else
    localparam int LAT = 28;
    localparam int DUTY_2_1 = 666;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CNT_W-1:0]  high_cnt = '0;
    logic [CNT_W-1:0]  low_cnt = '0;
    logic [CNT_W:0]    period;
    logic [DUTY_W-1:0] duty;
    logic              zero_period;
    logic              result_valid;
    logic              busy;

    pwm_param_calc #(.CNT_W(16), .SCALE(1000)) dut (
        .clk(clk), .rst(rst), .high_cnt(high_cnt), .low_cnt(low_cnt),
        .period(period), .duty(duty), .zero_period(zero_period),
        .result_valid(result_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected result from the arithmetic definition of period and duty.
    function automatic void calc(input int h, input int l, output int p, output int d);
        p = h + l;
        if (p == 0) d = 0;
`ifdef PWM_CALC_ROUND_EN
        else d = (h * 1000 + p / 2) / p;
`else
        else d = (h * 1000) / p;
`endif
    endfunction

    // Model: a run starts on any IDLE cycle whose inputs differ from the last accepted pair,
    // the result appears LAT cycles later, and the design is busy for the cycles in between.
    int m_snap_h = 0, m_snap_l = 0;
    bit m_active = 0;
    int m_start = 0, m_done = 0;
    int m_p = 0, m_d = 0;
    int e_p = 0, e_d = 0, e_z = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_v, exp_b;
            exp_v = m_active && (cyc == m_done);
            exp_b = m_active && (cyc > m_start) && (cyc <= m_done);
            if (exp_v) begin
                e_p = m_p; e_d = m_d; e_z = (m_p == 0);
            end
            chk("result_valid", 32'(result_valid), 32'(exp_v));
            chk("busy", 32'(busy), 32'(exp_b));
            chk("period", 32'(period), 32'(e_p));
            chk("duty", 32'(duty), 32'(e_d));
            chk("zero_period", 32'(zero_period), 32'(e_z));
            if (rst) begin
                m_snap_h = 0; m_snap_l = 0; m_active = 0;
                e_p = 0; e_d = 0; e_z = 0;
            end else if ((!m_active || cyc > m_done) &&
                         (int'(high_cnt) != m_snap_h || int'(low_cnt) != m_snap_l)) begin
                m_snap_h = int'(high_cnt);
                m_snap_l = int'(low_cnt);
                m_active = 1;
                m_start  = cyc;
                m_done   = cyc + LAT;
                calc(m_snap_h, m_snap_l, m_p, m_d);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && busy; i++) tick(1);
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Drives one input pair from IDLE and checks latency and literal results.
    task automatic directed(input string name, input int h, input int l,
                            input int ep, input int ed, input int ez);
        int k;
        wait_idle();
        high_cnt = CNT_W'(h);
        low_cnt  = CNT_W'(l);
        for (k = 1; k <= LAT + 10; k++) begin
            tick(1);
            if (result_valid) break;
        end
        chk({name, "_latency"}, 32'(k), 32'(LAT));
        chk({name, "_period"}, 32'(period), 32'(ep));
        chk({name, "_duty"}, 32'(duty), 32'(ed));
        chk({name, "_zero"}, 32'(zero_period), 32'(ez));
        tick(1);
    endtask

    initial begin
        int pulses, c1, c2, p1, d1, p2, d2, mode, h, l;
        tick(1);
        chk_en = 1;
        tick(2);
        chk("reset_period", 32'(period), 32'd0);
        chk("reset_duty", 32'(duty), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 0;
        tick(1);

        directed("t250_750", 250, 750, 1000, 250, 0);
        directed("t1_2", 1, 2, 3, 333, 0);
        directed("t2_1", 2, 1, 3, DUTY_2_1, 0);
        directed("t0_0", 0, 0, 0, 0, 1);
        directed("t500_0", 500, 0, 500, 1000, 0);
        directed("t0_5", 0, 5, 5, 0, 0);
        directed("tmax", 65535, 65535, 131070, 500, 0);

        // Changes while busy: only the latest pair is computed after the first result.
        wait_idle();
        high_cnt = 16'd250; low_cnt = 16'd750;
        pulses = 0; c1 = 0; c2 = 0; p1 = 0; d1 = 0; p2 = 0; d2 = 0;
        for (int k = 1; k <= 2 * LAT + 30; k++) begin
            tick(1);
            if (k == 5) begin high_cnt = 16'd100; low_cnt = 16'd300; end
            if (k == 10) begin high_cnt = 16'd400; low_cnt = 16'd400; end
            if (result_valid) begin
                pulses++;
                if (pulses == 1) begin c1 = k; p1 = int'(period); d1 = int'(duty); end
                if (pulses == 2) begin c2 = k; p2 = int'(period); d2 = int'(duty); end
            end
        end
        chk("busy_pulses", 32'(pulses), 32'd2);
        chk("busy_first_cycle", 32'(c1), 32'(LAT));
        chk("busy_first_period", 32'(p1), 32'd1000);
        chk("busy_first_duty", 32'(d1), 32'd250);
        chk("busy_second_cycle", 32'(c2), 32'(2 * LAT + 1));
        chk("busy_second_period", 32'(p2), 32'd800);
        chk("busy_second_duty", 32'(d2), 32'd500);

        // Reset in the middle of a division.
        wait_idle();
        high_cnt = 16'd300; low_cnt = 16'd100;
        tick(10);
        rst = 1;
        tick(1);
        chk("midrst_valid", 32'(result_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_period", 32'(period), 32'd0);
        chk("midrst_duty", 32'(duty), 32'd0);
        rst = 0;
        begin
            int k;
            for (k = 1; k <= LAT + 10; k++) begin
                tick(1);
                if (result_valid) break;
            end
            chk("rerun_latency", 32'(k), 32'(LAT));
            chk("rerun_period", 32'(period), 32'd400);
            chk("rerun_duty", 32'(duty), 32'd750);
        end

        // Randomized input changes at arbitrary times, checked by the model every cycle.
        for (int t = 0; t < 150; t++) begin
            tick($urandom_range(0, 40));
            mode = $urandom_range(0, 9);
            h = $urandom_range(0, 65535);
            l = $urandom_range(0, 65535);
            case (mode)
                0: begin h = 0; l = 0; end
                1: h = 0;
                2: l = 0;
                3: begin h = 65535; l = 65535; end
                4: begin h = $urandom_range(0, 7); l = $urandom_range(0, 7); end
                default: ;
            endcase
            high_cnt = CNT_W'(h);
            low_cnt  = CNT_W'(l);
        end
        wait_idle();
        tick(LAT + 5);
        wait_idle();
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
